vga_sync_gen: RTL and testbench

Raster timing generator for the VGA display path. It produces the pixel/line counters `hcount`/`vcount`, the `hsync`/`vsync` pulses and the `blank` flag. `blank` drives the blanking input (`sd`) of the pixel output stage directly downstream, which zeroes the pixel byte outside the visible area. The default timing is 640x480 @ 60 Hz, advanced by a pixel-rate clock enable.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_sync_gen.sv | 119 +++++++++++
 tb/tb_vga_sync_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants (default 640x480 @ 60 Hz) and sync polarity encoding.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam logic SYNC_POL = SYNC_ACTIVE_LOW;

  // Bounds are one bit wider than the counter so an upper bound of 1024 stays exact.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W:0]   lo,
                                     input logic [CNT_W:0]   hi);
    return ({1'b0, val} >= lo) && ({1'b0, val} < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, sync window and active-region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = H_ACTIVE,
  parameter int   FP     = H_FP,
  parameter int   SYNC   = H_SYNC,
  parameter int   BP     = H_BP,
  parameter logic POL    = SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active_nxt
);

  localparam int               TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   ACT_END = (CNT_W + 1)'(ACTIVE);
  localparam logic [CNT_W:0]   SYNC_LO = (CNT_W + 1)'(ACTIVE + FP);
  localparam logic [CNT_W:0]   SYNC_HI = (CNT_W + 1)'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;

  // Next count and the decodes derived from it, so registered outputs line up with the count.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (en) begin
      if (count_q == LAST) begin
        count_d = {CNT_W{1'b0}};
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 10'd1;
      end
    end else begin
      count_d = count_q;
    end
    sync_d     = in_window(count_d, SYNC_LO, SYNC_HI) ? POL : ~POL;
    active_nxt = ({1'b0, count_d} < ACT_END);
  end

  // Counter and sync registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= {CNT_W{1'b0}};
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters, syncs, blank and line/frame pulses.
// Optional frame counter is built only when VGA_FRAME_CNT_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  logic h_wrap, v_wrap;
  logic h_active_nxt, v_active_nxt;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (SYNC_POL)
  ) u_h_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (pix_en),
    .count      (hcount),
    .wrap       (h_wrap),
    .sync       (hsync),
    .active_nxt (h_active_nxt)
  );

  // The vertical axis advances only on the last pixel of a line.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (SYNC_POL)
  ) u_v_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .count      (vcount),
    .wrap       (v_wrap),
    .sync       (vsync),
    .active_nxt (v_active_nxt)
  );

  logic blank_q, blank_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Blank and pulses decoded from the next counts.
  always_comb begin
    blank_d       = ~(h_active_nxt & v_active_nxt);
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_wrap;
  end

  // Output registers for blank and pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps on the same edge as frame_start, wrapping modulo 256.
  always_comb begin
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen with a compact raster so several frames fit in the run.
// Reference model: count of enabled pixels since reset, mapped to (h, v) by division.
module tb_vga_sync_gen;

  localparam int   HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int   VA = 30, VF = 3, VS = 2, VB = 4;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FT = HT * VT;
  localparam logic POL = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [9:0] hcount, vcount;
  logic       hsync, vsync, blank, line_start, frame_start;
  logic [7:0] frame_cnt;

  int n_total = 0;
  int n_bad   = 0;

  int m_pix = 0;
  logic m_ls = 1'b0;
  logic m_fs = 1'b0;

  vga_sync_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      m_pix <= 0;
      m_ls  <= 1'b0;
      m_fs  <= 1'b0;
    end else if (pix_en) begin
      m_pix <= m_pix + 1;
      m_ls  <= ((m_pix + 1) % HT) == 0;
      m_fs  <= ((m_pix + 1) % FT) == 0;
    end else begin
      m_ls  <= 1'b0;
      m_fs  <= 1'b0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int   h, v;
    logic e_hs, e_vs, e_bl;
    int   e_fc;
    h    = m_pix % HT;
    v    = (m_pix / HT) % VT;
    e_hs = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
    e_vs = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
    e_bl = (h >= HA) || (v >= VA);
`ifdef VGA_FRAME_CNT_EN
    e_fc = (m_pix / FT) % 256;
`else
    e_fc = 0;
`endif
    chk_eq("hcount", 32'(hcount), 32'(h));
    chk_eq("vcount", 32'(vcount), 32'(v));
    chk_eq("hsync", 32'(hsync), 32'(e_hs));
    chk_eq("vsync", 32'(vsync), 32'(e_vs));
    chk_eq("blank", 32'(blank), 32'(e_bl));
    chk_eq("line_start", 32'(line_start), 32'(m_ls));
    chk_eq("frame_start", 32'(frame_start), 32'(m_fs));
    chk_eq("frame_cnt", 32'(frame_cnt), 32'(e_fc));
  endtask

  task automatic cycle(input logic r, input logic e);
    rst    = r;
    pix_en = e;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int budget;
    rst    = 1'b0;
    pix_en = 1'b1;
    @(negedge clk);

    // Reset held with pix_en high: explicit reset-state values.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    chk_eq("rst_hsync", 32'(hsync), 32'(1));
    chk_eq("rst_vsync", 32'(vsync), 32'(1));
    chk_eq("rst_blank", 32'(blank), 32'(0));

    // Continuous enable through a full frame wrap.
    for (int i = 0; i < FT + 2 * HT; i++) cycle(1'b1, 1'b1);

    // Enable toggling 1/0.
    for (int i = 0; i < 4 * HT; i++) cycle(1'b1, 1'(i % 2 == 0));

    // Random enable until mid-frame, then a one-cycle reset.
    budget = 4 * FT;
    while ((m_pix % FT) < FT / 2 && budget > 0) begin
      cycle(1'b1, 1'($urandom_range(0, 3) != 0));
      budget--;
    end
    chk_eq("mid_frame_reach", 32'(budget > 0), 32'(1));
    cycle(1'b0, 1'b1);
    chk_eq("mid_rst_h", 32'(hcount), 32'(0));
    chk_eq("mid_rst_v", 32'(vcount), 32'(0));
    chk_eq("mid_rst_fs", 32'(frame_start), 32'(0));

    // Random enable across further frames.
    for (int i = 0; i < 3 * FT; i++) cycle(1'b1, 1'($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
